// File: rtl/memory_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : memory_bus_arbiter
//  Description : Shares one Wishbone B4 classic master port between the
//                instruction-fetch requester and the load/store requester.
//                Runs one bus cycle at a time with a registered grant. The
//                winner under contention is either round-robin or
//                data-priority. Hung cycles are ended with an error after a
//                programmable timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module memory_bus_arbiter #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ROUND_ROBIN    = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    // instruction fetch requester
    input  logic                     fetch_request,
    input  logic [ADDRESS_WIDTH-1:0] fetch_address,
    output logic                     fetch_done,
    output logic [31:0]              fetch_read_data,
    output logic                     fetch_error,
    // load/store requester
    input  logic                     data_request,
    input  logic                     data_write,
    input  logic [ADDRESS_WIDTH-1:0] data_address,
    input  logic [3:0]               data_byte_select,
    input  logic [31:0]              data_write_data,
    output logic                     data_done,
    output logic [31:0]              data_read_data,
    output logic                     data_error,
    // Wishbone master port
    output logic                     wb_cyc,
    output logic                     wb_stb,
    output logic                     wb_we,
    output logic [ADDRESS_WIDTH-1:0] wb_adr,
    output logic [3:0]               wb_sel,
    output logic [31:0]              wb_dat_o,
    input  logic [31:0]              wb_dat_i,
    input  logic                     wb_ack,
    input  logic                     wb_err
);

    // The wait counter only has to reach TIMEOUT_CYCLES-1; the last wait
    // cycle is recognised while the counter holds that value.
    localparam int c_count_width = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_count_width-1:0] c_count_last =
        c_count_width'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    state_t                     r_state;
    logic                       r_wb_cyc;
    logic                       r_wb_we;
    logic [ADDRESS_WIDTH-1:0]   r_wb_adr;
    logic [3:0]                 r_wb_sel;
    logic [31:0]                r_wb_dat_o;
    logic                       r_fetch_done;
    logic                       r_fetch_error;
    logic [31:0]                r_fetch_read_data;
    logic                       r_data_done;
    logic                       r_data_error;
    logic [31:0]                r_data_read_data;
    logic                       r_data_next;   // round-robin pointer: 1 = data wins next tie
    logic [c_count_width-1:0]   r_count;

    logic                       w_grant_fetch;
    logic                       w_grant_data;
    logic                       w_contention;
    logic                       w_done_cycle;
    logic                       w_timeout;
    logic                       w_end;
    logic                       w_bus_error;
    logic [31:0]                w_read_word;
    logic [3:0]                 w_unused_addr_bits;

    // Word-aligned bus: the low address bits of both requesters are dropped.
    assign w_unused_addr_bits = {fetch_address[1:0], data_address[1:0]};

    assign w_contention = fetch_request & data_request;
    // No grant is issued on the cycle a done pulse is presented, so a
    // requester still holding its old request is not served twice.
    assign w_done_cycle = r_fetch_done | r_data_done;
    assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_count == c_count_last);
    assign w_end        = wb_ack | wb_err | w_timeout;
    // err wins over ack; a timeout only counts when no ack arrived
    assign w_bus_error  = wb_err | (w_timeout & ~wb_ack);
    assign w_read_word  = w_bus_error ? 32'h0 : wb_dat_i;

    // Pick the requester that would be granted in IDLE this cycle.
    always_comb begin
        w_grant_fetch = 1'b0;
        w_grant_data  = 1'b0;
        if (w_contention) begin
            if ((ROUND_ROBIN != 0) && !r_data_next) begin
                w_grant_fetch = 1'b1;
            end else begin
                w_grant_data  = 1'b1;
            end
        end else if (data_request) begin
            w_grant_data  = 1'b1;
        end else if (fetch_request) begin
            w_grant_fetch = 1'b1;
        end
    end

    // Bus-cycle state machine with registered bus and response outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state           <= S_IDLE;
            r_wb_cyc          <= 1'b0;
            r_wb_we           <= 1'b0;
            r_wb_adr          <= '0;
            r_wb_sel          <= 4'h0;
            r_wb_dat_o        <= 32'h0;
            r_fetch_done      <= 1'b0;
            r_fetch_error     <= 1'b0;
            r_fetch_read_data <= 32'h0;
            r_data_done       <= 1'b0;
            r_data_error      <= 1'b0;
            r_data_read_data  <= 32'h0;
            r_data_next       <= 1'b1;
            r_count           <= '0;
        end else begin
            // response outputs are single-cycle pulses
            r_fetch_done      <= 1'b0;
            r_fetch_error     <= 1'b0;
            r_fetch_read_data <= 32'h0;
            r_data_done       <= 1'b0;
            r_data_error      <= 1'b0;
            r_data_read_data  <= 32'h0;

            case (r_state)
                S_IDLE: begin
                    if (!w_done_cycle && (w_grant_fetch || w_grant_data)) begin
                        r_wb_cyc <= 1'b1;
                        r_count  <= '0;
                        if ((ROUND_ROBIN != 0) && w_contention) begin
                            r_data_next <= ~r_data_next;
                        end
                        if (w_grant_fetch) begin
                            r_wb_we    <= 1'b0;
                            r_wb_sel   <= 4'hF;
                            r_wb_adr   <= {fetch_address[ADDRESS_WIDTH-1:2], 2'b00};
                            r_wb_dat_o <= 32'h0;
                            r_state    <= S_FETCH;
                        end else begin
                            r_wb_we    <= data_write;
                            r_wb_sel   <= data_byte_select;
                            r_wb_adr   <= {data_address[ADDRESS_WIDTH-1:2], 2'b00};
                            r_wb_dat_o <= data_write_data;
                            r_state    <= S_DATA;
                        end
                    end
                end

                S_FETCH, S_DATA: begin
                    if (w_end) begin
                        r_wb_cyc <= 1'b0;
                        r_state  <= S_IDLE;
                        if (r_state == S_FETCH) begin
                            r_fetch_done      <= 1'b1;
                            r_fetch_error     <= w_bus_error;
                            r_fetch_read_data <= w_read_word;
                        end else begin
                            r_data_done       <= 1'b1;
                            r_data_error      <= w_bus_error;
                            r_data_read_data  <= r_wb_we ? 32'h0 : w_read_word;
                        end
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                default: begin
                    r_wb_cyc <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign wb_cyc          = r_wb_cyc;
    assign wb_stb          = r_wb_cyc;
    assign wb_we           = r_wb_we;
    assign wb_adr          = r_wb_adr;
    assign wb_sel          = r_wb_sel;
    assign wb_dat_o        = r_wb_dat_o;
    assign fetch_done      = r_fetch_done;
    assign fetch_error     = r_fetch_error;
    assign fetch_read_data = r_fetch_read_data;
    assign data_done       = r_data_done;
    assign data_error      = r_data_error;
    assign data_read_data  = r_data_read_data;

endmodule
`default_nettype wire

// File: tb/tb_memory_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_bus_arbiter
//  Description : Self-checking bench for memory_bus_arbiter. Instance 0 runs
//                round-robin with a 4-cycle timeout, instance 1 runs
//                data-priority with no timeout. Directed scenarios plus
//                randomized transactions checked against a transaction-level
//                model of the arbitration rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memory_bus_arbiter;

    localparam int AW = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic          fetch_request    [2];
    logic [AW-1:0] fetch_address    [2];
    logic          fetch_done       [2];
    logic [31:0]   fetch_read_data  [2];
    logic          fetch_error      [2];
    logic          data_request     [2];
    logic          data_write       [2];
    logic [AW-1:0] data_address     [2];
    logic [3:0]    data_byte_select [2];
    logic [31:0]   data_write_data  [2];
    logic          data_done        [2];
    logic [31:0]   data_read_data   [2];
    logic          data_error       [2];
    logic          wb_cyc           [2];
    logic          wb_stb           [2];
    logic          wb_we            [2];
    logic [AW-1:0] wb_adr           [2];
    logic [3:0]    wb_sel           [2];
    logic [31:0]   wb_dat_o         [2];
    logic [31:0]   wb_dat_i         [2];
    logic          wb_ack           [2];
    logic          wb_err           [2];

    int total = 0;
    int bad   = 0;
    bit model_data_next [2];   // model's round-robin pointer (1 = data wins next tie)

    for (genvar g = 0; g < 2; g++) begin : g_dut
        memory_bus_arbiter #(
            .ADDRESS_WIDTH (AW),
            .TIMEOUT_CYCLES((g == 0) ? 4 : 0),
            .ROUND_ROBIN   ((g == 0) ? 1 : 0)
        ) dut (
            .clock           (clock),
            .reset           (reset),
            .fetch_request   (fetch_request[g]),
            .fetch_address   (fetch_address[g]),
            .fetch_done      (fetch_done[g]),
            .fetch_read_data (fetch_read_data[g]),
            .fetch_error     (fetch_error[g]),
            .data_request    (data_request[g]),
            .data_write      (data_write[g]),
            .data_address    (data_address[g]),
            .data_byte_select(data_byte_select[g]),
            .data_write_data (data_write_data[g]),
            .data_done       (data_done[g]),
            .data_read_data  (data_read_data[g]),
            .data_error      (data_error[g]),
            .wb_cyc          (wb_cyc[g]),
            .wb_stb          (wb_stb[g]),
            .wb_we           (wb_we[g]),
            .wb_adr          (wb_adr[g]),
            .wb_sel          (wb_sel[g]),
            .wb_dat_o        (wb_dat_o[g]),
            .wb_dat_i        (wb_dat_i[g]),
            .wb_ack          (wb_ack[g]),
            .wb_err          (wb_err[g])
        );
    end

    function automatic int timeout_of(int u);
        return (u == 0) ? 4 : 0;
    endfunction

    function automatic bit rr_of(int u);
        return (u == 0);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs(int u);
        fetch_request[u]    = 1'b0;
        fetch_address[u]    = '0;
        data_request[u]     = 1'b0;
        data_write[u]       = 1'b0;
        data_address[u]     = '0;
        data_byte_select[u] = 4'h0;
        data_write_data[u]  = 32'h0;
        wb_dat_i[u]         = 32'h0;
        wb_ack[u]           = 1'b0;
        wb_err[u]           = 1'b0;
    endtask

    // Advance until the bus cycle starts or the budget expires.
    task automatic wait_cyc(int u, int budget, output int n);
        n = 0;
        while (wb_cyc[u] !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs(0);
        idle_inputs(1);
        repeat (2) @(posedge clock);
        #1;
        for (int u = 0; u < 2; u++) begin
            total++; if ({wb_cyc[u], wb_stb[u], wb_we[u]} !== 3'b000) begin bad++; $display("FAIL reset_bus_ctl u=%0d got=%b exp=000", u, {wb_cyc[u], wb_stb[u], wb_we[u]}); end
            total++; if ({wb_adr[u], wb_sel[u], wb_dat_o[u]} !== 68'h0) begin bad++; $display("FAIL reset_bus_data u=%0d adr=%h sel=%h dat=%h exp=0", u, wb_adr[u], wb_sel[u], wb_dat_o[u]); end
            total++; if ({fetch_done[u], fetch_error[u], data_done[u], data_error[u]} !== 4'b0) begin bad++; $display("FAIL reset_done u=%0d got=%b exp=0000", u, {fetch_done[u], fetch_error[u], data_done[u], data_error[u]}); end
            total++; if ({fetch_read_data[u], data_read_data[u]} !== 64'h0) begin bad++; $display("FAIL reset_rdata u=%0d f=%h d=%h exp=0", u, fetch_read_data[u], data_read_data[u]); end
            model_data_next[u] = 1'b1;
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fetch_only();
        for (int u = 0; u < 2; u++) begin
            fetch_request[u] = 1'b1;
            fetch_address[u] = 32'h100;
            tick();
            total++; if ({wb_cyc[u], wb_stb[u], wb_we[u], wb_sel[u]} !== 7'b110_1111) begin bad++; $display("FAIL fetch_ctl u=%0d got=%b exp=1101111", u, {wb_cyc[u], wb_stb[u], wb_we[u], wb_sel[u]}); end
            total++; if (wb_adr[u] !== 32'h100) begin bad++; $display("FAIL fetch_adr u=%0d got=%h exp=100", u, wb_adr[u]); end
            wb_ack[u]   = 1'b1;
            wb_dat_i[u] = 32'h0050_0093;
            tick();
            wb_ack[u] = 1'b0;
            total++; if ({fetch_done[u], fetch_error[u], data_done[u], wb_cyc[u]} !== 4'b1000) begin bad++; $display("FAIL fetch_done u=%0d got=%b exp=1000", u, {fetch_done[u], fetch_error[u], data_done[u], wb_cyc[u]}); end
            total++; if (fetch_read_data[u] !== 32'h0050_0093) begin bad++; $display("FAIL fetch_rdata u=%0d got=%h exp=00500093", u, fetch_read_data[u]); end
            fetch_request[u] = 1'b0;
            tick();
            total++; if ({fetch_done[u], fetch_read_data[u]} !== 33'h0) begin bad++; $display("FAIL fetch_pulse u=%0d got done=%b data=%h exp=0", u, fetch_done[u], fetch_read_data[u]); end
        end
    endtask

    task automatic test_store();
        for (int u = 0; u < 2; u++) begin
            data_request[u]     = 1'b1;
            data_write[u]       = 1'b1;
            data_address[u]     = 32'h2003;
            data_byte_select[u] = 4'b1000;
            data_write_data[u]  = 32'hAB00_0000;
            tick();
            total++; if ({wb_cyc[u], wb_we[u], wb_sel[u]} !== 6'b11_1000) begin bad++; $display("FAIL store_ctl u=%0d got=%b exp=111000", u, {wb_cyc[u], wb_we[u], wb_sel[u]}); end
            total++; if ({wb_adr[u], wb_dat_o[u]} !== {32'h2000, 32'hAB00_0000}) begin bad++; $display("FAIL store_bus u=%0d adr=%h dat=%h exp=2000/ab000000", u, wb_adr[u], wb_dat_o[u]); end
            wb_ack[u]   = 1'b1;
            wb_dat_i[u] = 32'hFFFF_FFFF;
            tick();
            wb_ack[u] = 1'b0;
            total++; if ({data_done[u], data_error[u], fetch_done[u], data_read_data[u]} !== {3'b100, 32'h0}) begin bad++; $display("FAIL store_done u=%0d done=%b err=%b data=%h exp=1/0/0", u, data_done[u], data_error[u], data_read_data[u]); end
            data_request[u] = 1'b0;
            data_write[u]   = 1'b0;
            tick();
        end
    endtask

    task automatic test_contention(int u);
        int  n;
        bit  own_data;
        logic [31:0] dat;
        fetch_request[u]    = 1'b1;
        fetch_address[u]    = 32'h1008;
        data_request[u]     = 1'b1;
        data_write[u]       = 1'b0;
        data_address[u]     = 32'h3004;
        data_byte_select[u] = 4'h3;
        for (int j = 0; j < 4; j++) begin
            if (rr_of(u)) begin
                own_data = model_data_next[u];
                model_data_next[u] = !model_data_next[u];
            end else begin
                own_data = 1'b1;
            end
            wait_cyc(u, 10, n);
            total++; if (n !== ((j == 0) ? 1 : 2)) begin bad++; $display("FAIL contend_gap u=%0d txn=%0d got=%0d exp=%0d", u, j, n, (j == 0) ? 1 : 2); end
            total++; if (wb_adr[u] !== (own_data ? 32'h3004 : 32'h1008)) begin bad++; $display("FAIL contend_grant u=%0d txn=%0d adr=%h exp=%h", u, j, wb_adr[u], own_data ? 32'h3004 : 32'h1008); end
            dat = $urandom;
            wb_ack[u]   = 1'b1;
            wb_dat_i[u] = dat;
            tick();
            wb_ack[u] = 1'b0;
            total++; if ({data_done[u], fetch_done[u]} !== {own_data, !own_data}) begin bad++; $display("FAIL contend_done u=%0d txn=%0d got d=%b f=%b exp d=%b", u, j, data_done[u], fetch_done[u], own_data); end
            total++; if ((own_data ? data_read_data[u] : fetch_read_data[u]) !== dat) begin bad++; $display("FAIL contend_rdata u=%0d txn=%0d got=%h exp=%h", u, j, own_data ? data_read_data[u] : fetch_read_data[u], dat); end
        end
        fetch_request[u] = 1'b0;
        data_request[u]  = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        fetch_request[0] = 1'b1;
        fetch_address[0] = 32'h400;
        wb_dat_i[0]      = 32'hDEAD_BEEF;
        tick();
        n = 0;
        while (wb_cyc[0] === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++; if (n !== 4) begin bad++; $display("FAIL timeout_len got=%0d exp=4", n); end
        total++; if ({fetch_done[0], fetch_error[0], fetch_read_data[0]} !== {2'b11, 32'h0}) begin bad++; $display("FAIL timeout_done done=%b err=%b data=%h exp=1/1/0", fetch_done[0], fetch_error[0], fetch_read_data[0]); end
        fetch_request[0] = 1'b0;
        tick();
        // bus error on the second wait cycle
        data_request[0]     = 1'b1;
        data_write[0]       = 1'b0;
        data_address[0]     = 32'h500;
        data_byte_select[0] = 4'hF;
        tick();
        tick();
        total++; if (wb_cyc[0] !== 1'b1) begin bad++; $display("FAIL err_wait2_cyc got=%b exp=1", wb_cyc[0]); end
        wb_err[0] = 1'b1;
        tick();
        wb_err[0] = 1'b0;
        total++; if ({wb_cyc[0], data_done[0], data_error[0], data_read_data[0]} !== {3'b011, 32'h0}) begin bad++; $display("FAIL err_wait2_done cyc=%b done=%b err=%b data=%h exp=0/1/1/0", wb_cyc[0], data_done[0], data_error[0], data_read_data[0]); end
        data_request[0] = 1'b0;
        wb_dat_i[0]     = 32'h0;
        tick();
    endtask

    task automatic test_no_timeout();
        int viol = 0;
        fetch_request[1] = 1'b1;
        fetch_address[1] = 32'h800;
        tick();
        for (int i = 0; i < 999; i++) begin
            if (wb_cyc[1] !== 1'b1 || fetch_done[1] !== 1'b0) viol++;
            tick();
        end
        total++; if (viol !== 0) begin bad++; $display("FAIL notimeout_hold got=%0d bad cycles exp=0", viol); end
        wb_ack[1]   = 1'b1;
        wb_dat_i[1] = 32'h1357_9BDF;
        tick();
        wb_ack[1] = 1'b0;
        total++; if ({fetch_done[1], fetch_error[1], fetch_read_data[1]} !== {2'b10, 32'h1357_9BDF}) begin bad++; $display("FAIL notimeout_done done=%b err=%b data=%h exp=1/0/13579bdf", fetch_done[1], fetch_error[1], fetch_read_data[1]); end
        fetch_request[1] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_cycle();
        int n;
        fetch_request[0]    = 1'b1;
        fetch_address[0]    = 32'h1008;
        data_request[0]     = 1'b1;
        data_write[0]       = 1'b0;
        data_address[0]     = 32'h3004;
        data_byte_select[0] = 4'hF;
        // data wins the first tie, leaving the pointer on fetch
        wait_cyc(0, 10, n);
        model_data_next[0] = 1'b0;
        wb_ack[0] = 1'b1;
        tick();
        wb_ack[0] = 1'b0;
        wait_cyc(0, 10, n);
        total++; if (wb_adr[0] !== 32'h1008) begin bad++; $display("FAIL prereset_grant adr=%h exp=1008", wb_adr[0]); end
        reset = 1'b0;
        #1;
        total++; if (wb_cyc[0] !== 1'b0) begin bad++; $display("FAIL reset_drop_cyc got=%b exp=0", wb_cyc[0]); end
        n = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (fetch_done[0] !== 1'b0 || data_done[0] !== 1'b0) n++;
        end
        total++; if (n !== 0) begin bad++; $display("FAIL reset_no_done got=%0d pulses exp=0", n); end
        reset = 1'b1;
        model_data_next[0] = 1'b1;
        model_data_next[1] = 1'b1;
        wait_cyc(0, 10, n);
        model_data_next[0] = 1'b0;
        total++; if ({n[3:0], wb_adr[0]} !== {4'd1, 32'h3004}) begin bad++; $display("FAIL postreset_grant wait=%0d adr=%h exp=1/3004", n, wb_adr[0]); end
        wb_ack[0] = 1'b1;
        tick();
        wb_ack[0] = 1'b0;
        fetch_request[0] = 1'b0;
        data_request[0]  = 1'b0;
        tick();
    endtask

    task automatic test_random(int u, int iters);
        for (int it = 0; it < iters; it++) begin
            int          pat, k, e, viol, to;
            bit          fr, dr, own_data, use_err, timed, exp_err, drop, hold_over;
            logic [31:0] faddr, daddr, dwd, dat, exp_rd, got_rd;
            logic [31:0] exp_adr;
            logic [3:0]  dsel;
            logic        dwe;
            pat   = $urandom_range(1, 3);
            fr    = pat[0];
            dr    = pat[1];
            faddr = $urandom;
            daddr = $urandom;
            dwd   = $urandom;
            dsel  = 4'($urandom);
            dwe   = 1'($urandom);
            if (fr && dr) begin
                if (rr_of(u)) begin
                    own_data = model_data_next[u];
                    model_data_next[u] = !model_data_next[u];
                end else begin
                    own_data = 1'b1;
                end
            end else begin
                own_data = dr;
            end
            fetch_request[u]    = fr;
            fetch_address[u]    = faddr;
            data_request[u]     = dr;
            data_write[u]       = dwe;
            data_address[u]     = daddr;
            data_byte_select[u] = dsel;
            data_write_data[u]  = dwd;
            // stray terminations while idle must be ignored
            wb_ack[u]   = 1'($urandom);
            wb_err[u]   = 1'($urandom);
            wb_dat_i[u] = $urandom;
            tick();
            wb_ack[u] = 1'b0;
            wb_err[u] = 1'b0;
            exp_adr = own_data ? {daddr[31:2], 2'b00} : {faddr[31:2], 2'b00};
            total++; if ({wb_cyc[u], wb_stb[u], wb_adr[u]} !== {2'b11, exp_adr}) begin bad++; $display("FAIL rnd_grant u=%0d it=%0d cyc=%b adr=%h exp adr=%h", u, it, wb_cyc[u], wb_adr[u], exp_adr); end
            total++; if ({wb_we[u], wb_sel[u]} !== (own_data ? {dwe, dsel} : 5'b0_1111)) begin bad++; $display("FAIL rnd_we_sel u=%0d it=%0d got=%b exp=%b", u, it, {wb_we[u], wb_sel[u]}, own_data ? {dwe, dsel} : 5'b0_1111); end
            if (own_data) begin
                total++; if (wb_dat_o[u] !== dwd) begin bad++; $display("FAIL rnd_dat_o u=%0d it=%0d got=%h exp=%h", u, it, wb_dat_o[u], dwd); end
            end
            k       = $urandom_range(1, 6);
            use_err = ($urandom_range(0, 3) == 0);
            to      = timeout_of(u);
            timed   = (to > 0) && (k > to);
            e       = timed ? to : k;
            exp_err = timed || use_err;
            dat     = $urandom;
            drop    = 1'($urandom);
            viol    = 0;
            for (int i = 1; i <= e; i++) begin
                if (wb_cyc[u] !== 1'b1 || fetch_done[u] !== 1'b0 || data_done[u] !== 1'b0) viol++;
                if (i == 1 && drop) begin
                    fetch_request[u] = 1'b0;
                    data_request[u]  = 1'b0;
                end
                if (i == k) begin
                    wb_err[u]   = use_err;
                    wb_ack[u]   = use_err ? 1'($urandom) : 1'b1;
                    wb_dat_i[u] = dat;
                end else begin
                    wb_dat_i[u] = $urandom;
                end
                tick();
            end
            wb_ack[u] = 1'b0;
            wb_err[u] = 1'b0;
            exp_rd = (exp_err || (own_data && dwe)) ? 32'h0 : dat;
            got_rd = own_data ? data_read_data[u] : fetch_read_data[u];
            total++; if (viol !== 0) begin bad++; $display("FAIL rnd_wait u=%0d it=%0d got=%0d bad cycles exp=0", u, it, viol); end
            total++; if ({wb_cyc[u], data_done[u], fetch_done[u]} !== {1'b0, own_data, !own_data}) begin bad++; $display("FAIL rnd_done u=%0d it=%0d got cyc=%b d=%b f=%b exp d=%b", u, it, wb_cyc[u], data_done[u], fetch_done[u], own_data); end
            total++; if ((own_data ? data_error[u] : fetch_error[u]) !== exp_err) begin bad++; $display("FAIL rnd_error u=%0d it=%0d got=%b exp=%b", u, it, own_data ? data_error[u] : fetch_error[u], exp_err); end
            total++; if (got_rd !== exp_rd) begin bad++; $display("FAIL rnd_rdata u=%0d it=%0d got=%h exp=%h", u, it, got_rd, exp_rd); end
            hold_over = 1'($urandom);
            if (!hold_over) begin
                fetch_request[u] = 1'b0;
                data_request[u]  = 1'b0;
            end
            tick();
            total++; if ({wb_cyc[u], fetch_done[u], data_done[u], fetch_read_data[u], data_read_data[u]} !== 67'h0) begin bad++; $display("FAIL rnd_quiet u=%0d it=%0d cyc=%b fd=%b dd=%b exp=0", u, it, wb_cyc[u], fetch_done[u], data_done[u]); end
            fetch_request[u] = 1'b0;
            data_request[u]  = 1'b0;
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_store();
        test_contention(0);
        test_contention(1);
        test_timeout();
        test_no_timeout();
        test_reset_mid_cycle();
        test_random(0, 40);
        test_random(1, 40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
